pipe_stage_chain: RTL and testbench
===================================

// Module: pipe_stage_chain
// PURPOSE
//   Parametrised inter-stage pipeline register chain that replaces the per-stage hand-written
//   D/E, E/M and M/W registers. It carries an opaque control/data payload plus the fields every
//   stage must treat specially: PC, T_new, exception code, branch-delay flag and a valid bit.
//   DEPTH back-to-back slices share one stall, flush and exception-request interface, so one
//   instance can model a multi-cycle stage. Per-slice T_new and valid are exported to the hazard unit.
// PARAMETERS
//   PAYLOAD_W   64            width of opaque payload (ReadData, imm, CU controls, reg addrs)
//   TNEW_W      2             width of T_new field
//   DEPTH       1             number of chained slices (>=1)
//   HANDLER_PC  32'h0000_4180 PC loaded into every slice on exception request
//   CNT_W       16            width of bubble counter (PIPE_BUBBLE_CNT_EN only)
// PORTS
//   clk          in   1               clock
//   reset        in   1               reset, synchronous, active-high
//   en           in   1               advance enable; 0 = whole chain holds
//   flush        in   1               insert bubble into slice 0 (hazard stall upstream)
//   req          in   1               exception/interrupt request: clear entire chain
//   in_valid     in   1               upstream entry valid
//   in_payload   in   PAYLOAD_W       upstream payload
//   in_pc        in   32              upstream PC
//   in_tnew      in   TNEW_W          upstream T_new
//   in_exc       in   5               upstream exception code
//   in_bd        in   1               upstream branch-delay flag
//   out_valid    out  1               last-slice valid
//   out_payload  out  PAYLOAD_W       last-slice payload
//   out_pc       out  32              last-slice PC
//   out_tnew     out  TNEW_W          last-slice T_new
//   out_exc      out  5               last-slice exception code
//   out_bd       out  1               last-slice branch-delay flag
//   stage_valid  out  DEPTH           valid of each slice, bit k = slice k
//   stage_tnew   out  DEPTH*TNEW_W    T_new of each slice, slice k at [k*TNEW_W +: TNEW_W]
//   bubble_cnt   out  CNT_W           bubbles inserted (PIPE_BUBBLE_CNT_EN only)
// BEHAVIOUR
//   - Priority per cycle: reset > req > flush > en > hold. All updates on posedge clk.
//   - reset: every slice valid=0, payload=0, pc=0, tnew=0, exc=0, bd=0; bubble_cnt=0.
//   - req: every slice valid=0, payload=0, tnew=0, exc=0, bd=0, pc=HANDLER_PC. This applies
//     regardless of en/flush.
//   - flush (no req): slice 0 gets valid=0, payload=0, tnew=0, exc=0, pc=in_pc, bd=in_bd
//     (bubble keeps PC/BD for EPC). Slices 1..DEPTH-1 advance as if en=1, even when en=0.
//   - en=1 (no req/flush): slice 0 <= inputs; slice k <= slice k-1; tnew is saturating-
//     decremented on every load: next = (src==0) ? 0 : src-1. Other fields copy unchanged.
//   - en=0 (no req/flush): all slices hold all fields.
//   - Latency: DEPTH cycles from input to out_* when en=1 continuously.
//   - Zero-combinational path: outputs driven from flops only; stage_* likewise.
//   - DEPTH=1 is functionally identical to the legacy D/E register with valid added.
// CONFIGURATION
//   PIPE_BUBBLE_CNT_EN defined: bubble_cnt increments by 1 on each cycle with flush=1 and
//     req=0 and reset=0; it saturates at all-ones and is cleared only by reset.
//   PIPE_BUBBLE_CNT_EN undefined: the counter flops are absent and bubble_cnt is tied to 0.
//     The port is still present.
// STRUCTURE
//   - pipe_pkg: HANDLER_PC_DEFAULT, EXC_W=5, and the tnew_dec() saturating-decrement function.
//   - Sub-module pipe_stage_slice: one slice with load/bubble/clear/hold inputs.
//   - pipe_stage_chain generates DEPTH slices and wires priority control and the counter.
// TESTING
//   1 DEPTH=1, en=1, in_tnew=2, pc=0x3000, valid=1 -> next cycle out_tnew=1, out_pc=0x3000, out_valid=1.
//   2 DEPTH=1, in_tnew=0 -> out_tnew=0 (no wrap to 3).
//   3 flush=1, en=0, in_pc=0x3010, in_bd=1 -> out_valid=0, out_pc=0x3010, out_bd=1, payload=0.
//     With PIPE_BUBBLE_CNT_EN, bubble_cnt=1.
//   4 DEPTH=3 full of valid entries, req=1 with flush=1 and en=1 -> all stage_valid=0,
//     all pc=0x4180, bd=0.
//   5 DEPTH=3, en=0 for 4 cycles, then en=1 -> contents unchanged while stalled.
//     Entry with in_tnew=3 exits after 3 cycles with tnew=0; stage_tnew shows 2,1,0.
//   6 reset asserted mid-stream together with req -> all outputs 0 (pc=0, not 0x4180).
//     bubble_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the inter-stage pipeline register chain.
package pipe_pkg;

    localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;
    localparam int unsigned EXC_W              = 5;
    // Widest T_new the decrement helper handles; narrower fields are zero-extended.
    localparam int unsigned TNEW_MAX_W         = 8;

    function automatic logic [TNEW_MAX_W-1:0] tnew_dec(input logic [TNEW_MAX_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_MAX_W'(1);
    endfunction

endpackage

// File: rtl/pipe_stage_slice.sv
// One pipeline register slice: clear > bubble > load > hold, with synchronous active-high reset.
module pipe_stage_slice
    import pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W  = 64,
    parameter int unsigned TNEW_W     = 2,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 bubble,
    input  logic                 load,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [31:0]          in_pc,
    input  logic [TNEW_W-1:0]    in_tnew,
    input  logic [EXC_W-1:0]     in_exc,
    input  logic                 in_bd,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [31:0]          out_pc,
    output logic [TNEW_W-1:0]    out_tnew,
    output logic [EXC_W-1:0]     out_exc,
    output logic                 out_bd
);

    logic                  valid_q,   valid_d;
    logic [PAYLOAD_W-1:0]  payload_q, payload_d;
    logic [31:0]           pc_q,      pc_d;
    logic [TNEW_W-1:0]     tnew_q,    tnew_d;
    logic [EXC_W-1:0]      exc_q,     exc_d;
    logic                  bd_q,      bd_d;
    logic [TNEW_MAX_W-1:0] tnew_next;

    assign tnew_next = tnew_dec(TNEW_MAX_W'(in_tnew));

    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        pc_d      = pc_q;
        tnew_d    = tnew_q;
        exc_d     = exc_q;
        bd_d      = bd_q;
        if (clear) begin
            valid_d   = 1'b0;
            payload_d = '0;
            pc_d      = HANDLER_PC;
            tnew_d    = '0;
            exc_d     = '0;
            bd_d      = 1'b0;
        end else if (bubble) begin
            // The bubble keeps PC and BD so a later exception still reports a sensible EPC.
            valid_d   = 1'b0;
            payload_d = '0;
            pc_d      = in_pc;
            tnew_d    = '0;
            exc_d     = '0;
            bd_d      = in_bd;
        end else if (load) begin
            valid_d   = in_valid;
            payload_d = in_payload;
            pc_d      = in_pc;
            tnew_d    = tnew_next[TNEW_W-1:0];
            exc_d     = in_exc;
            bd_d      = in_bd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
            pc_q      <= '0;
            tnew_q    <= '0;
            exc_q     <= '0;
            bd_q      <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
            pc_q      <= pc_d;
            tnew_q    <= tnew_d;
            exc_q     <= exc_d;
            bd_q      <= bd_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_payload = payload_q;
    assign out_pc      = pc_q;
    assign out_tnew    = tnew_q;
    assign out_exc     = exc_q;
    assign out_bd      = bd_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH chained pipeline slices sharing stall/flush/exception control.
// Optional bubble counter enabled by defining PIPE_BUBBLE_CNT_EN.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W  = 64,
    parameter int unsigned TNEW_W     = 2,
    parameter int unsigned DEPTH      = 1,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      flush,
    input  logic                      req,
    input  logic                      in_valid,
    input  logic [PAYLOAD_W-1:0]      in_payload,
    input  logic [31:0]               in_pc,
    input  logic [TNEW_W-1:0]         in_tnew,
    input  logic [EXC_W-1:0]          in_exc,
    input  logic                      in_bd,
    output logic                      out_valid,
    output logic [PAYLOAD_W-1:0]      out_payload,
    output logic [31:0]               out_pc,
    output logic [TNEW_W-1:0]         out_tnew,
    output logic [EXC_W-1:0]          out_exc,
    output logic                      out_bd,
    output logic [DEPTH-1:0]          stage_valid,
    output logic [DEPTH*TNEW_W-1:0]   stage_tnew,
    output logic [CNT_W-1:0]          bubble_cnt
);

    logic [DEPTH-1:0]     s_valid;
    logic [PAYLOAD_W-1:0] s_payload [DEPTH];
    logic [31:0]          s_pc      [DEPTH];
    logic [TNEW_W-1:0]    s_tnew    [DEPTH];
    logic [EXC_W-1:0]     s_exc     [DEPTH];
    logic [DEPTH-1:0]     s_bd;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slice
        logic                 src_valid;
        logic [PAYLOAD_W-1:0] src_payload;
        logic [31:0]          src_pc;
        logic [TNEW_W-1:0]    src_tnew;
        logic [EXC_W-1:0]     src_exc;
        logic                 src_bd;
        logic                 slice_load;
        logic                 slice_bubble;

        if (k == 0) begin : g_head
            assign src_valid    = in_valid;
            assign src_payload  = in_payload;
            assign src_pc       = in_pc;
            assign src_tnew     = in_tnew;
            assign src_exc      = in_exc;
            assign src_bd       = in_bd;
            assign slice_load   = en;
            assign slice_bubble = flush;
        end else begin : g_body
            assign src_valid    = s_valid[k-1];
            assign src_payload  = s_payload[k-1];
            assign src_pc       = s_pc[k-1];
            assign src_tnew     = s_tnew[k-1];
            assign src_exc      = s_exc[k-1];
            assign src_bd       = s_bd[k-1];
            // A flush only bubbles the head; downstream slices keep draining.
            assign slice_load   = en | flush;
            assign slice_bubble = 1'b0;
        end

        pipe_stage_slice #(
            .PAYLOAD_W  (PAYLOAD_W),
            .TNEW_W     (TNEW_W),
            .HANDLER_PC (HANDLER_PC)
        ) u_slice (
            .clk         (clk),
            .reset       (reset),
            .clear       (req),
            .bubble      (slice_bubble),
            .load        (slice_load),
            .in_valid    (src_valid),
            .in_payload  (src_payload),
            .in_pc       (src_pc),
            .in_tnew     (src_tnew),
            .in_exc      (src_exc),
            .in_bd       (src_bd),
            .out_valid   (s_valid[k]),
            .out_payload (s_payload[k]),
            .out_pc      (s_pc[k]),
            .out_tnew    (s_tnew[k]),
            .out_exc     (s_exc[k]),
            .out_bd      (s_bd[k])
        );

        assign stage_tnew[k*TNEW_W +: TNEW_W] = s_tnew[k];
    end

    assign stage_valid = s_valid;
    assign out_valid   = s_valid[DEPTH-1];
    assign out_payload = s_payload[DEPTH-1];
    assign out_pc      = s_pc[DEPTH-1];
    assign out_tnew    = s_tnew[DEPTH-1];
    assign out_exc     = s_exc[DEPTH-1];
    assign out_bd      = s_bd[DEPTH-1];

`ifdef PIPE_BUBBLE_CNT_EN
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (flush && !req && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`else
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed self-checking bench: a DEPTH=1 and a DEPTH=3 chain driven from shared inputs.
module tb_pipe_stage_chain;

    localparam int unsigned PW = 64;
    localparam int unsigned TW = 2;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          reset, en, flush, req;
    logic          in_valid, in_bd;
    logic [PW-1:0] in_payload;
    logic [31:0]   in_pc;
    logic [TW-1:0] in_tnew;
    logic [4:0]    in_exc;

    logic          o1_valid, o1_bd;
    logic [PW-1:0] o1_payload;
    logic [31:0]   o1_pc;
    logic [TW-1:0] o1_tnew;
    logic [4:0]    o1_exc;
    logic [0:0]    s1_valid;
    logic [TW-1:0] s1_tnew;
    logic [CW-1:0] c1;

    logic            o3_valid, o3_bd;
    logic [PW-1:0]   o3_payload;
    logic [31:0]     o3_pc;
    logic [TW-1:0]   o3_tnew;
    logic [4:0]      o3_exc;
    logic [2:0]      s3_valid;
    logic [3*TW-1:0] s3_tnew;
    logic [CW-1:0]   c3;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pipe_stage_chain #(.PAYLOAD_W(PW), .TNEW_W(TW), .DEPTH(1), .CNT_W(CW)) dut1 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .req(req),
        .in_valid(in_valid), .in_payload(in_payload), .in_pc(in_pc), .in_tnew(in_tnew),
        .in_exc(in_exc), .in_bd(in_bd),
        .out_valid(o1_valid), .out_payload(o1_payload), .out_pc(o1_pc), .out_tnew(o1_tnew),
        .out_exc(o1_exc), .out_bd(o1_bd), .stage_valid(s1_valid), .stage_tnew(s1_tnew),
        .bubble_cnt(c1)
    );

    pipe_stage_chain #(.PAYLOAD_W(PW), .TNEW_W(TW), .DEPTH(3), .CNT_W(CW)) dut3 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .req(req),
        .in_valid(in_valid), .in_payload(in_payload), .in_pc(in_pc), .in_tnew(in_tnew),
        .in_exc(in_exc), .in_bd(in_bd),
        .out_valid(o3_valid), .out_payload(o3_payload), .out_pc(o3_pc), .out_tnew(o3_tnew),
        .out_exc(o3_exc), .out_bd(o3_bd), .stage_valid(s3_valid), .stage_tnew(s3_tnew),
        .bubble_cnt(c3)
    );

    // Expected bubble count after n flush cycles since reset.
    function automatic logic [CW-1:0] exp_cnt(input int n);
`ifdef PIPE_BUBBLE_CNT_EN
        return CW'(n);
`else
        return '0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [TW-1:0] t,
                         input logic bd, input logic [PW-1:0] pl, input logic [4:0] ex);
        in_valid   = v;
        in_pc      = pc;
        in_tnew    = t;
        in_bd      = bd;
        in_payload = pl;
        in_exc     = ex;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; flush = 1'b0; req = 1'b0;
        drive(1'b0, 32'h0, 2'd0, 1'b0, '0, 5'd0);
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b1, 32'h1234, 2'd3, 1'b1, 64'hFFFF, 5'd7);
        reset = 1'b1; en = 1'b1;
        step();
        reset = 1'b0; en = 1'b0;
        n_total++;
        if ({o1_valid, o1_pc, o1_tnew, o1_bd, o1_exc} !== '0 || o1_payload !== '0)
            $display("FAIL reset_d1: valid=%b pc=%h tnew=%0d bd=%b exc=%h pl=%h, required all 0",
                     o1_valid, o1_pc, o1_tnew, o1_bd, o1_exc, o1_payload);
        else n_pass++;
        n_total++;
        if (s3_valid !== 3'b000 || s3_tnew !== 6'd0 || o3_pc !== 32'h0)
            $display("FAIL reset_d3: stage_valid=%b stage_tnew=%h pc=%h, required 0",
                     s3_valid, s3_tnew, o3_pc);
        else n_pass++;
        n_total++;
        if (c1 !== '0) $display("FAIL reset_cnt: got %0d required 0", c1);
        else n_pass++;
    endtask

    task automatic test_load();
        do_reset();
        en = 1'b1;
        drive(1'b1, 32'h3000, 2'd2, 1'b0, 64'hDEAD_BEEF_0123_4567, 5'h0A);
        step();
        n_total++;
        if (o1_tnew !== 2'd1 || o1_pc !== 32'h3000 || o1_valid !== 1'b1)
            $display("FAIL load_basic: tnew=%0d pc=%h valid=%b, required 1 3000 1",
                     o1_tnew, o1_pc, o1_valid);
        else n_pass++;
        n_total++;
        if (o1_payload !== 64'hDEAD_BEEF_0123_4567 || o1_exc !== 5'h0A || o1_bd !== 1'b0)
            $display("FAIL load_fields: pl=%h exc=%h bd=%b, required deadbeef01234567 0a 0",
                     o1_payload, o1_exc, o1_bd);
        else n_pass++;
        n_total++;
        if (s3_valid !== 3'b001 || s3_tnew !== 6'b00_00_01)
            $display("FAIL load_d3_head: valid=%b tnew=%b, required 001 000001", s3_valid, s3_tnew);
        else n_pass++;
    endtask

    task automatic test_tnew_sat();
        drive(1'b1, 32'h3004, 2'd0, 1'b1, 64'h1, 5'd0);
        step();
        n_total++;
        if (o1_tnew !== 2'd0 || o1_bd !== 1'b1)
            $display("FAIL tnew_zero: tnew=%0d bd=%b, required 0 1", o1_tnew, o1_bd);
        else n_pass++;
        drive(1'b1, 32'h3008, 2'd3, 1'b0, 64'h2, 5'd0);
        step();
        n_total++;
        if (o1_tnew !== 2'd2) $display("FAIL tnew_three: tnew=%0d required 2", o1_tnew);
        else n_pass++;
        en = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        en = 1'b0; flush = 1'b1;
        drive(1'b1, 32'h3010, 2'd3, 1'b1, 64'hABCD, 5'd3);
        step();
        flush = 1'b0;
        n_total++;
        if (o1_valid !== 1'b0 || o1_pc !== 32'h3010 || o1_bd !== 1'b1)
            $display("FAIL flush_bubble: valid=%b pc=%h bd=%b, required 0 3010 1",
                     o1_valid, o1_pc, o1_bd);
        else n_pass++;
        n_total++;
        if (o1_payload !== '0 || o1_tnew !== 2'd0 || o1_exc !== 5'd0)
            $display("FAIL flush_zeroed: pl=%h tnew=%0d exc=%h, required 0 0 0",
                     o1_payload, o1_tnew, o1_exc);
        else n_pass++;
        n_total++;
        if (c1 !== exp_cnt(1)) $display("FAIL flush_cnt: got %0d required %0d", c1, exp_cnt(1));
        else n_pass++;
    endtask

    task automatic test_flush_advance();
        do_reset();
        en = 1'b1;
        drive(1'b1, 32'h0500, 2'd3, 1'b0, 64'h55, 5'd0);
        step();
        en = 1'b0; flush = 1'b1;
        drive(1'b1, 32'h0300, 2'd1, 1'b0, 64'h66, 5'd0);
        step();
        flush = 1'b0;
        // Head became a bubble while the older entry moved into slice 1 despite en=0.
        n_total++;
        if (s3_valid !== 3'b010 || s3_tnew !== 6'b00_01_00)
            $display("FAIL flush_advance: valid=%b tnew=%b, required 010 000100", s3_valid, s3_tnew);
        else n_pass++;
        n_total++;
        if (c3 !== exp_cnt(1)) $display("FAIL flush_adv_cnt: got %0d required %0d", c3, exp_cnt(1));
        else n_pass++;
    endtask

    task automatic test_req();
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0100 + 32'(4 * i), 2'd3, 1'b1, 64'(i + 1), 5'd1);
            step();
        end
        n_total++;
        if (s3_valid !== 3'b111 || o3_pc !== 32'h0100)
            $display("FAIL req_fill: valid=%b pc=%h, required 111 100", s3_valid, o3_pc);
        else n_pass++;
        req = 1'b1; flush = 1'b1;
        step();
        req = 1'b0; flush = 1'b0; en = 1'b0;
        n_total++;
        if (s3_valid !== 3'b000 || o3_pc !== 32'h0000_4180 || o3_bd !== 1'b0 || s3_tnew !== 6'd0)
            $display("FAIL req_clear_d3: valid=%b pc=%h bd=%b tnew=%h, required 000 4180 0 0",
                     s3_valid, o3_pc, o3_bd, s3_tnew);
        else n_pass++;
        n_total++;
        if (o1_pc !== 32'h0000_4180 || o1_valid !== 1'b0 || o1_payload !== '0)
            $display("FAIL req_clear_d1: pc=%h valid=%b pl=%h, required 4180 0 0",
                     o1_pc, o1_valid, o1_payload);
        else n_pass++;
        n_total++;
        if (c3 !== '0) $display("FAIL req_no_count: got %0d required 0", c3);
        else n_pass++;
    endtask

    task automatic test_stall();
        do_reset();
        en = 1'b1;
        drive(1'b1, 32'h0200, 2'd3, 1'b0, 64'h77, 5'd2);
        step();
        en = 1'b0;
        drive(1'b0, 32'h0, 2'd0, 1'b0, '0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            n_total++;
            if (s3_valid !== 3'b001 || s3_tnew !== 6'b00_00_10)
                $display("FAIL stall_hold%0d: valid=%b tnew=%b, required 001 000010",
                         i, s3_valid, s3_tnew);
            else n_pass++;
        end
        en = 1'b1;
        step();
        n_total++;
        if (s3_valid !== 3'b010 || s3_tnew !== 6'b00_01_00)
            $display("FAIL stall_mid: valid=%b tnew=%b, required 010 000100", s3_valid, s3_tnew);
        else n_pass++;
        step();
        n_total++;
        if (o3_valid !== 1'b1 || o3_pc !== 32'h0200 || o3_tnew !== 2'd0 || o3_exc !== 5'd2)
            $display("FAIL stall_exit: valid=%b pc=%h tnew=%0d exc=%h, required 1 200 0 02",
                     o3_valid, o3_pc, o3_tnew, o3_exc);
        else n_pass++;
        en = 1'b0;
    endtask

    task automatic test_reset_req();
        do_reset();
        en = 1'b1;
        drive(1'b1, 32'h0600, 2'd2, 1'b1, 64'h99, 5'd4);
        step();
        step();
        flush = 1'b1;
        step();
        step();
        flush = 1'b0;
        n_total++;
        if (c3 !== exp_cnt(2)) $display("FAIL pre_reset_cnt: got %0d required %0d", c3, exp_cnt(2));
        else n_pass++;
        reset = 1'b1; req = 1'b1;
        step();
        reset = 1'b0; req = 1'b0; en = 1'b0;
        n_total++;
        if (o3_pc !== 32'h0 || o1_pc !== 32'h0 || s3_valid !== 3'b000 || o3_bd !== 1'b0)
            $display("FAIL reset_over_req: pc3=%h pc1=%h valid=%b bd=%b, required 0 0 000 0",
                     o3_pc, o1_pc, s3_valid, o3_bd);
        else n_pass++;
        n_total++;
        if (c3 !== '0 || c1 !== '0) $display("FAIL reset_cnt_clr: got %0d/%0d required 0", c3, c1);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; flush = 1'b0; req = 1'b0;
        drive(1'b0, 32'h0, 2'd0, 1'b0, '0, 5'd0);
        test_reset();
        test_load();
        test_tnew_sat();
        test_flush();
        test_flush_advance();
        test_req();
        test_stall();
        test_reset_req();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
